// File: rtl/layer_argmax_8_16_if.sv
// Handshake bundle for the argmax classifier stage: activation input stream and result output.
// The slave modport is the classifier's view; master is the surrounding pipeline/host view.
interface layer_argmax_8_16_if #(
  parameter int T    = 16,
  parameter int LOGM = 3
);
  logic                   s_valid;
  logic                   s_ready;
  logic signed [T-1:0]    data_in;
  logic                   m_valid;
  logic                   m_ready;
  logic        [LOGM-1:0] class_out;
  logic signed [T-1:0]    score_out;

  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, class_out, score_out
  );

  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, class_out, score_out
  );
endinterface

// File: rtl/layer_argmax_8_16.sv
// Argmax over M serial signed activations per vector; emits winning index and score.
// Optional macro LAYER_ARGMAX_OVERLAP_EN lets the next vector start in the result handshake cycle.
module layer_argmax_8_16 #(
  parameter int T    = 16,
  parameter int M    = 8,
  parameter int LOGM = 3
) (
  input logic                clk,
  input logic                reset,
  layer_argmax_8_16_if.slave bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t                 state;
  logic        [LOGM-1:0] in_count;
  logic signed [T-1:0]    best_val;
  logic        [LOGM-1:0] best_idx;
  logic                   accept;
  logic                   last_elem;

  always_comb begin
    bus.s_ready = 1'b0;
    case (state)
      COLLECT: bus.s_ready = 1'b1;
      DONE: begin
`ifdef LAYER_ARGMAX_OVERLAP_EN
        bus.s_ready = bus.m_ready;
`else
        bus.s_ready = 1'b0;
`endif
      end
      default: bus.s_ready = 1'b0;
    endcase
  end

  assign accept    = bus.s_valid && bus.s_ready;
  assign last_elem = (in_count == LOGM'(M - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      in_count <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            // Element 0 loads unconditionally; strict '>' keeps the lower index on ties.
            if (in_count == '0) begin
              best_val <= bus.data_in;
              best_idx <= '0;
            end else if (bus.data_in > best_val) begin
              best_val <= bus.data_in;
              best_idx <= in_count;
            end
            if (last_elem) begin
              in_count <= '0;
              state    <= DONE;
            end else begin
              in_count <= in_count + LOGM'(1);
            end
          end
        end
        DONE: begin
          if (bus.m_ready) begin
            state <= COLLECT;
`ifdef LAYER_ARGMAX_OVERLAP_EN
            // An element taken alongside the result handshake is element 0 of the next vector.
            if (accept) begin
              best_val <= bus.data_in;
              best_idx <= '0;
              in_count <= LOGM'(1);
            end
`endif
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.m_valid   = (state == DONE);
  assign bus.class_out = best_idx;
  assign bus.score_out = best_val;

endmodule

// File: tb/tb_layer_argmax_8_16.sv
// Directed self-checking bench for layer_argmax_8_16 (default and LAYER_ARGMAX_OVERLAP_EN builds).
module tb_layer_argmax_8_16;
  typedef logic signed [15:0] vec_t [8];

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  layer_argmax_8_16_if #(.T(16), .LOGM(3)) bus ();

  layer_argmax_8_16 #(.T(16), .M(8), .LOGM(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Feeds the first n elements of v, one accept per cycle, waiting (bounded) on s_ready.
  task automatic feed(input vec_t v, input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      bus.data_in = v[i];
      bus.s_valid = 1'b1;
      while (!bus.s_ready && guard < 20) begin
        step();
        guard++;
      end
      if (guard >= 20) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout: s_ready=%0b after %0d cycles, required 1", bus.s_ready, guard);
      end
      step();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic release_result;
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.data_in = '0;
    step();
    step();
    reset = 1'b0;
    step();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b want 1", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b want 0", bus.m_valid); end
    checks++; if (bus.class_out !== 3'd0) begin errors++; $display("FAIL reset_class: got %0d want 0", bus.class_out); end
    checks++; if (bus.score_out !== 16'sd0) begin errors++; $display("FAIL reset_score: got %0d want 0", bus.score_out); end
  endtask

  task automatic test_tie;
    vec_t v = '{16'sd5, -16'sd3, 16'sd100, 16'sd7, 16'sd100, 16'sd0, 16'sd2, 16'sd1};
    feed(v, 8);
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL tie_latency: m_valid=%0b want 1", bus.m_valid); end
    checks++; if (bus.class_out !== 3'd2) begin errors++; $display("FAIL tie_class: got %0d want 2", bus.class_out); end
    checks++; if (bus.score_out !== 16'sd100) begin errors++; $display("FAIL tie_score: got %0d want 100", bus.score_out); end
    release_result();
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL tie_single_pulse: m_valid=%0b want 0", bus.m_valid); end
  endtask

  task automatic test_zero;
    vec_t z = '{default: 16'sd0};
    vec_t w = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd9};
    feed(z, 8);
    checks++; if (bus.class_out !== 3'd0) begin errors++; $display("FAIL zero_class: got %0d want 0", bus.class_out); end
    checks++; if (bus.score_out !== 16'sd0) begin errors++; $display("FAIL zero_score: got %0d want 0", bus.score_out); end
    release_result();
    feed(w, 8);
    checks++; if (bus.class_out !== 3'd7) begin errors++; $display("FAIL last_class: got %0d want 7", bus.class_out); end
    checks++; if (bus.score_out !== 16'sd9) begin errors++; $display("FAIL last_score: got %0d want 9", bus.score_out); end
    release_result();
  endtask

  task automatic test_negative;
    vec_t v = '{-16'sd5, -16'sd2, -16'sd9, -16'sd2, -16'sd100, -16'sd7, -16'sd3, -16'sd4};
    logic signed [15:0] want = -16'sd2;
    feed(v, 8);
    checks++; if (bus.class_out !== 3'd1) begin errors++; $display("FAIL neg_class: got %0d want 1", bus.class_out); end
    checks++; if (bus.score_out !== want) begin errors++; $display("FAIL neg_score: got %0d want %0d", bus.score_out, want); end
    release_result();
  endtask

  task automatic test_backpressure;
    vec_t v = '{16'sd3, 16'sd1, 16'sd4, 16'sd1, 16'sd5, 16'sd9, 16'sd2, 16'sd6};
    feed(v, 8);
    for (int c = 0; c < 5; c++) begin
      bus.s_valid = c[0];
      bus.data_in = 16'sh7fff;
      step();
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid[%0d]: got %0b want 1", c, bus.m_valid); end
      checks++; if (bus.class_out !== 3'd5) begin errors++; $display("FAIL bp_class[%0d]: got %0d want 5", c, bus.class_out); end
      checks++; if (bus.score_out !== 16'sd9) begin errors++; $display("FAIL bp_score[%0d]: got %0d want 9", c, bus.score_out); end
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready[%0d]: got %0b want 0", c, bus.s_ready); end
    end
    bus.s_valid = 1'b0;
    release_result();
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL bp_after_m_valid: got %0b want 0", bus.m_valid); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_after_s_ready: got %0b want 1", bus.s_ready); end
  endtask

  task automatic test_mid_reset;
    vec_t big = '{default: 16'sd100};
    vec_t v   = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8};
    feed(big, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %0b want 0", bus.m_valid); end
    feed(v, 8);
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL midrst_done: m_valid=%0b want 1", bus.m_valid); end
    checks++; if (bus.class_out !== 3'd7) begin errors++; $display("FAIL midrst_class: got %0d want 7", bus.class_out); end
    checks++; if (bus.score_out !== 16'sd8) begin errors++; $display("FAIL midrst_score: got %0d want 8", bus.score_out); end
    // Reset while the result is pending drops it.
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL donerst_m_valid: got %0b want 0", bus.m_valid); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL donerst_s_ready: got %0b want 1", bus.s_ready); end
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] stream [16] = '{16'sd5, -16'sd3, 16'sd100, 16'sd7, 16'sd100, 16'sd0, 16'sd2, 16'sd1,
                                        16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd9};
    logic [2:0]         got_c [2];
    logic signed [15:0] got_s [2];
    int hs_cyc [2];
    int idx = 0, cyc = 0, nhs = 0, first = 0;
    logic acc, hs, acc_at_hs0 = 1'b0;
`ifdef LAYER_ARGMAX_OVERLAP_EN
    int   want_span = 17, want_gap = 8;
    logic want_ov = 1'b1;
`else
    int   want_span = 18, want_gap = 9;
    logic want_ov = 1'b0;
`endif
    got_c = '{default: '0};
    got_s = '{default: '0};
    hs_cyc = '{default: 0};
    bus.m_ready = 1'b1;
    while (nhs < 2 && cyc < 40) begin
      bus.s_valid = (idx < 16);
      bus.data_in = stream[(idx < 16) ? idx : 15];
      acc = bus.s_valid && bus.s_ready;
      hs  = bus.m_valid && bus.m_ready;
`ifndef LAYER_ARGMAX_OVERLAP_EN
      if (bus.m_valid) begin
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_s_ready@%0d: got %0b want 0", cyc, bus.s_ready); end
      end
`endif
      if (hs) begin
        got_c[nhs] = bus.class_out;
        got_s[nhs] = bus.score_out;
        if (nhs == 0) acc_at_hs0 = acc;
      end
      step();
      cyc++;
      if (acc) begin
        if (first == 0) first = cyc;
        idx++;
      end
      if (hs) begin
        hs_cyc[nhs] = cyc;
        nhs++;
      end
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    checks++; if (nhs != 2) begin errors++; $display("FAIL b2b_timeout: results=%0d want 2", nhs); end
    checks++; if (got_c[0] !== 3'd2 || got_s[0] !== 16'sd100) begin errors++; $display("FAIL b2b_first: class=%0d score=%0d want 2/100", got_c[0], got_s[0]); end
    checks++; if (got_c[1] !== 3'd7 || got_s[1] !== 16'sd9) begin errors++; $display("FAIL b2b_second: class=%0d score=%0d want 7/9", got_c[1], got_s[1]); end
    checks++; if (hs_cyc[1] - first + 1 != want_span) begin errors++; $display("FAIL b2b_span: got %0d want %0d", hs_cyc[1] - first + 1, want_span); end
    checks++; if (hs_cyc[1] - hs_cyc[0] != want_gap) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", hs_cyc[1] - hs_cyc[0], want_gap); end
    checks++; if (acc_at_hs0 !== want_ov) begin errors++; $display("FAIL b2b_overlap_accept: got %0b want %0b", acc_at_hs0, want_ov); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_zero();
    test_negative();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
